pipeline_bubble_injector: RTL
=============================

Name: pipeline_bubble_injector

Overview:
- Owns the ID/EX pipeline register. Drives the hazard-control lines for the PC and IF/ID register.
- On a load-use hazard or a taken branch, it replaces the ID/EX contents with an all-zero NOP bubble. Opcode 6'b000000 and all control bits are 0.
- Downstream EX-stage logic recognises the bubble through its 6-input all-zero opcode detect.

Parameters:
- CTRL_WIDTH, 8, width of the ID-stage control word forwarded to EX.
- STALL_CYCLES, 1, cycles that PC and IF/ID are frozen per load-use hazard. Legal range 1..7.
- CNT_WIDTH, 16, width of the saturating bubble counter.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  ID stage holds a real instruction.
- id_opcode  in  6  decoded opcode.
- id_rs  in  5  source register 1.
- id_rt  in  5  source register 2 / load destination.
- id_rd  in  5  destination register.
- id_mem_read  in  1  ID instruction is a load.
- id_ctrl  in  CTRL_WIDTH  remaining control bits.
- branch_taken  in  1  EX resolved a taken branch this cycle.
- ex_valid  out  1  registered ID/EX valid.
- ex_opcode  out  6  registered opcode.
- ex_rs, ex_rt, ex_rd  out  5 each  registered register fields.
- ex_mem_read  out  1  registered load flag.
- ex_ctrl  out  CTRL_WIDTH  registered control bits.
- pc_write  out  1  PC update enable (combinational).
- ifid_write  out  1  IF/ID update enable (combinational).
- ifid_flush  out  1  IF/ID clear (combinational).
- bubble_count  out  CNT_WIDTH  total bubbles injected since reset, saturating.

Behaviour:
- Clock and reset:
  - Single clock `clock`.
  - Reset `reset` is synchronous, active-high.
- Reset values:
  - All ex_* outputs are 0.
  - bubble_count is 0.
  - State is RUN and the stall counter is 0.
  - Combinational outputs while reset is asserted: pc_write=1, ifid_write=1, ifid_flush=0.
  - Reset mid-stall or mid-flush returns to RUN on the next edge. No residual stall.
- Hazard and bubble definitions:
  - hazard = id_valid & ex_valid & ex_mem_read & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt).
  - A bubble loads all ex_* registers with 0 and increments bubble_count.
  - bubble_count saturates at all-ones and never wraps.
- States: RUN, LOAD_STALL. Stall counter is 3 bits.
- RUN, branch_taken=1 (highest priority):
  - ifid_flush=1, pc_write=1, ifid_write=1.
  - Bubble on the edge; stay in RUN.
- RUN, hazard=1, branch_taken=0:
  - pc_write=0, ifid_write=0 in the same cycle.
  - Bubble on the edge.
  - If STALL_CYCLES>1: go to LOAD_STALL with cnt=STALL_CYCLES-1. Otherwise stay in RUN.
- RUN, no event:
  - pc_write=1, ifid_write=1.
  - ex_* <= id_* on the edge, with ex_valid <= id_valid.
- LOAD_STALL, branch_taken=0:
  - pc_write=0, ifid_write=0, bubble each cycle, cnt decrements.
  - When cnt==1, go to RUN on the edge.
  - Total frozen cycles per hazard = STALL_CYCLES exactly.
- LOAD_STALL, branch_taken=1:
  - Abort the stall: ifid_flush=1, pc_write=1, bubble.
  - Go to RUN and clear cnt.
- id_valid=0 with no event:
  - The ID contents pass through with ex_valid=0.
  - This is not counted as a bubble.
  - No hazard can fire.
- After a stall, the held ID instruction is re-evaluated in RUN. The bubble has cleared ex_mem_read, so it advances.
- Latency: ID to EX is 1 cycle. Control outputs have zero latency and depend on the current state and inputs.

Decomposition:
- Shared package pipeline_pkg holds:
  - OPCODE_W=6 and REG_W=5.
  - NOP_OPCODE=6'b000000.
  - Enum bubble_state_t {RUN, LOAD_STALL}.
- One natural sub-module: load_use_detect. It is purely combinational: hazard from the ex_* and id_* fields.

Test Plan:
- Reset, then ID "add r3,r1,r2" with id_valid=1 -> next cycle ex_opcode/ex_rd=3 match input; pc_write=1; bubble_count=0.
- Load to r5, then ID uses rs=5, STALL_CYCLES=1 -> one cycle of pc_write=0, ifid_write=0; ex_* all 0; bubble_count=1; the dependent instruction reaches EX one cycle later.
- Same as above but the load targets r0 -> no stall, bubble_count unchanged.
- STALL_CYCLES=3 with a load-use hazard -> pc_write low exactly 3 cycles; 3 bubbles; bubble_count=3.
- STALL_CYCLES=3, branch_taken in the 2nd stall cycle -> ifid_flush=1 that cycle; pc_write=1; back to RUN; bubble_count=2.
- Force bubble_count to all-ones minus 1 via 2 branches near the limit -> the counter holds at 0xFFFF. Assert reset mid-LOAD_STALL -> next cycle pc_write=1 and all ex_* are 0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared widths, the NOP encoding and the hazard-controller state type
// for the ID/EX bubble injector.
package pipeline_pkg;
  localparam int OPCODE_W = 6;
  localparam int REG_W    = 5;

  localparam logic [OPCODE_W-1:0] NOP_OPCODE = 6'b000000;

  typedef enum logic {
    RUN        = 1'b0,
    LOAD_STALL = 1'b1
  } bubble_state_t;
endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use detector. It flags an ID instruction that reads the
// destination of a load that currently sits in EX.
module load_use_detect
  import pipeline_pkg::*;
(
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic             hazard
);
  // r0 is hard-wired zero, so a load into it never creates a dependency.
  assign hazard = id_valid & ex_valid & ex_mem_read & (ex_rt != '0) &
                  ((ex_rt == id_rs) | (ex_rt == id_rt));
endmodule

// File: rtl/pipeline_bubble_injector.sv
// ID/EX pipeline register with bubble injection on load-use hazards and
// taken branches, plus the PC / IF-ID hazard-control lines.
module pipeline_bubble_injector
  import pipeline_pkg::*;
#(
  parameter int CTRL_WIDTH   = 8,
  parameter int STALL_CYCLES = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [OPCODE_W-1:0]   id_opcode,
  input  logic [REG_W-1:0]      id_rs,
  input  logic [REG_W-1:0]      id_rt,
  input  logic [REG_W-1:0]      id_rd,
  input  logic                  id_mem_read,
  input  logic [CTRL_WIDTH-1:0] id_ctrl,
  input  logic                  branch_taken,
  output logic                  ex_valid,
  output logic [OPCODE_W-1:0]   ex_opcode,
  output logic [REG_W-1:0]      ex_rs,
  output logic [REG_W-1:0]      ex_rt,
  output logic [REG_W-1:0]      ex_rd,
  output logic                  ex_mem_read,
  output logic [CTRL_WIDTH-1:0] ex_ctrl,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic [CNT_WIDTH-1:0]  bubble_count
);
  bubble_state_t         state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]  bubble_count_q, bubble_count_d;
  logic                  ex_valid_q, ex_mem_read_q;
  logic [OPCODE_W-1:0]   ex_opcode_q;
  logic [REG_W-1:0]      ex_rs_q, ex_rt_q, ex_rd_q;
  logic [CTRL_WIDTH-1:0] ex_ctrl_q;
  logic                  hazard;
  logic                  bubble;

  load_use_detect u_detect (
    .ex_valid    (ex_valid_q),
    .ex_mem_read (ex_mem_read_q),
    .ex_rt       (ex_rt_q),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .hazard      (hazard)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    bubble     = 1'b0;
    if (!reset) begin
      case (state_q)
        RUN: begin
          if (branch_taken) begin
            ifid_flush = 1'b1;
            bubble     = 1'b1;
          end else if (hazard) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            bubble     = 1'b1;
            if (STALL_CYCLES > 1) begin
              state_d = LOAD_STALL;
              cnt_d   = 3'(STALL_CYCLES - 1);
            end
          end
        end
        LOAD_STALL: begin
          bubble = 1'b1;
          if (branch_taken) begin
            ifid_flush = 1'b1;
            state_d    = RUN;
            cnt_d      = '0;
          end else begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            cnt_d      = cnt_q - 3'd1;
            if (cnt_q == 3'd1) state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    bubble_count_d = bubble_count_q;
    if (bubble && (bubble_count_q != '1)) bubble_count_d = bubble_count_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= RUN;
      cnt_q          <= '0;
      bubble_count_q <= '0;
      ex_valid_q     <= 1'b0;
      ex_opcode_q    <= NOP_OPCODE;
      ex_rs_q        <= '0;
      ex_rt_q        <= '0;
      ex_rd_q        <= '0;
      ex_mem_read_q  <= 1'b0;
      ex_ctrl_q      <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      bubble_count_q <= bubble_count_d;
      if (bubble) begin
        ex_valid_q    <= 1'b0;
        ex_opcode_q   <= NOP_OPCODE;
        ex_rs_q       <= '0;
        ex_rt_q       <= '0;
        ex_rd_q       <= '0;
        ex_mem_read_q <= 1'b0;
        ex_ctrl_q     <= '0;
      end else begin
        ex_valid_q    <= id_valid;
        ex_opcode_q   <= id_opcode;
        ex_rs_q       <= id_rs;
        ex_rt_q       <= id_rt;
        ex_rd_q       <= id_rd;
        ex_mem_read_q <= id_mem_read;
        ex_ctrl_q     <= id_ctrl;
      end
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_opcode    = ex_opcode_q;
  assign ex_rs        = ex_rs_q;
  assign ex_rt        = ex_rt_q;
  assign ex_rd        = ex_rd_q;
  assign ex_mem_read  = ex_mem_read_q;
  assign ex_ctrl      = ex_ctrl_q;
  assign bubble_count = bubble_count_q;
endmodule
